// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline slice.
// Holds no types; parameter-derived widths are computed by each module.
package elastic_pipe_pkg;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Valid/ready handshake bundle for both sides of an elastic pipeline,
// plus the synchronous flush that travels with it.
interface elastic_pipe_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;

  // master: the environment feeding the pipe and draining its output
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/elastic_pipe_stage.sv
// One register stage of the elastic pipeline: a valid bit and a data word
// that load from upstream whenever the stage is allowed to advance.
module pipe_stage #(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Data only moves with a valid entry and never during flush, so bubbles
  // and discarded entries leave the register contents untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= INIT;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// Bubble-collapsing elastic pipeline of DEPTH register stages with a
// valid/ready handshake on both ends, flush, and a registered occupancy count.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int unsigned     CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_q, count_d;

  // Advance chain resolved in one block, walking from the output back to
  // the input, so an empty stage anywhere lets everything behind it move.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = out_ready | ~v[DEPTH-1];
    for (int unsigned k = DEPTH - 1; k > 0; k--) begin
      adv[k-1] = adv[k] | ~v[k-1];
    end
  end

  assign in_ready = adv[0] & ~flush & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = v[DEPTH-1] & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             stage_in_valid;
    logic [WIDTH-1:0] stage_in_data;

    if (k == 0) begin : g_head
      assign stage_in_valid = push;
      assign stage_in_data  = in_data;
    end else begin : g_body
      assign stage_in_valid = v[k-1];
      assign stage_in_data  = d[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .adv      (adv[k]),
      .in_valid (stage_in_valid),
      .in_data  (stage_in_data),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  // Occupancy tracks pushes and pops; entries are conserved, so this equals
  // the number of set valid bits without a popcount tree.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: a DEPTH=3 instance for reset, streaming,
// stall, simultaneous push/pop, flush and mid-run reset, and a DEPTH=4 one for bubble collapse.
module tb_elastic_pipe;

  logic       clk;
  logic       rst;
  logic [1:0] cnt3;
  logic [2:0] cnt4;

  int checks;
  int errors;

  elastic_pipe_if #(.WIDTH(8)) if3 ();
  elastic_pipe_if #(.WIDTH(8)) if4 ();

  elastic_pipe #(
    .WIDTH (8),
    .DEPTH (3),
    .INIT  (8'hA5)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (if3.flush),
    .in_valid  (if3.in_valid),
    .in_data   (if3.in_data),
    .in_ready  (if3.in_ready),
    .out_valid (if3.out_valid),
    .out_data  (if3.out_data),
    .out_ready (if3.out_ready),
    .count     (cnt3)
  );

  elastic_pipe #(
    .WIDTH (8),
    .DEPTH (4),
    .INIT  (8'h00)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .flush     (if4.flush),
    .in_valid  (if4.in_valid),
    .in_data   (if4.in_data),
    .in_ready  (if4.in_ready),
    .out_valid (if4.out_valid),
    .out_data  (if4.out_data),
    .out_ready (if4.out_ready),
    .count     (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0; if3.flush = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0; if4.flush = 1'b0;

    // reset
    tick();
    check("rst_hold_rdy", if3.in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_vld", if3.out_valid, 0);
    check("rst_data", if3.out_data, 32'hA5);
    check("rst_cnt", cnt3, 0);
    check("rst_rdy", if3.in_ready, 1);
    check("rst4_data", if4.out_data, 0);
    check("rst4_cnt", cnt4, 0);

    // streaming: latency 3, back-to-back outputs
    if3.out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if3.in_valid = (t < 4);
      if3.in_data  = 8'(t + 1);
      tick();
      check("stream_vld", if3.out_valid, (t >= 2 && t <= 5));
      if (t >= 2 && t <= 5) check("stream_data", if3.out_data, t - 1);
    end
    check("stream_cnt", cnt3, 0);

    // fill with out_ready low, then drain
    if3.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(10 + i);
      #1;
      check("fill_rdy", if3.in_ready, (i < 3));
      tick();
    end
    if3.in_valid = 1'b0;
    check("fill_cnt", cnt3, 3);
    check("fill_vld", if3.out_valid, 1);
    check("fill_data", if3.out_data, 10);
    tick();
    check("stall_data", if3.out_data, 10);
    if3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_data", if3.out_data, 10 + i);
      tick();
      check("drain_cnt", cnt3, 2 - i);
    end
    check("drain_vld", if3.out_valid, 0);

    // simultaneous push/pop while full
    if3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(20 + i);
      tick();
    end
    check("full_cnt", cnt3, 3);
    if3.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if3.in_data = 8'(23 + i);
      #1;
      check("pp_rdy", if3.in_ready, 1);
      check("pp_data", if3.out_data, 20 + i);
      tick();
      check("pp_cnt", cnt3, 3);
    end
    if3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pp_drain", if3.out_data, 24 + i);
      tick();
    end
    check("pp_end_cnt", cnt3, 0);

    // flush with a concurrent push
    if3.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(30 + i);
      tick();
    end
    check("fl_pre_cnt", cnt3, 2);
    if3.flush   = 1'b1;
    if3.in_data = 8'd99;
    #1;
    check("fl_rdy", if3.in_ready, 0);
    tick();
    if3.flush    = 1'b0;
    if3.in_valid = 1'b0;
    check("fl_cnt", cnt3, 0);
    check("fl_vld", if3.out_valid, 0);
    check("fl_data_kept", if3.out_data, 26);
    if3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_after_vld", if3.out_valid, 0);
    end

    // reset mid-operation
    if3.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(40 + i);
      tick();
    end
    if3.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_cnt", cnt3, 0);
    check("mrst_vld", if3.out_valid, 0);
    check("mrst_data", if3.out_data, 32'hA5);

    // bubble collapse on DEPTH=4
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_data   = 8'd50;
    tick();
    if4.in_valid = 1'b0;
    check("bub_cnt1", cnt4, 1);
    check("bub_vld1", if4.out_valid, 0);
    for (int t = 2; t <= 4; t++) begin
      tick();
      check("bub_vld", if4.out_valid, (t == 4));
    end
    check("bub_data", if4.out_data, 50);
    for (int i = 0; i < 3; i++) begin
      if4.in_valid = 1'b1;
      if4.in_data  = 8'(51 + i);
      #1;
      check("bub_rdy", if4.in_ready, 1);
      tick();
    end
    if4.in_data = 8'd54;
    #1;
    check("bub_full_rdy", if4.in_ready, 0);
    check("bub_cnt4", cnt4, 4);
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bub_drain", if4.out_data, 50 + i);
      tick();
    end
    check("bub_end_cnt", cnt4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have parameter INIT, default 0, reset value of every stage data register.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream has in_data available.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_data  output  WIDTH  payload of last stage.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold per stage k (0..DEPTH-1) one valid bit v[k] and one WIDTH-bit data register d[k]; stage 0 nearest input.
REQ-015 SHALL define adv[DEPTH-1] = out_ready OR NOT v[DEPTH-1]; adv[k] = adv[k+1] OR NOT v[k] for k<DEPTH-1 (combinational, bubble-collapsing).
REQ-016 SHALL drive in_ready = adv[0] AND NOT flush AND NOT rst.
REQ-017 SHALL, when adv[k]=1, load d[k] from d[k-1] (or in_data for k=0) and v[k] from v[k-1] (or in_valid AND in_ready for k=0); when adv[k]=0 stage holds.
REQ-018 SHALL load d[k] only when adv[k]=1 and the incoming valid is 1; data registers SHALL otherwise hold.
REQ-019 SHALL drive out_valid = v[DEPTH-1], out_data = d[DEPTH-1].
REQ-020 SHALL transfer input when in_valid AND in_ready, output when out_valid AND out_ready.
REQ-021 SHALL give latency DEPTH cycles from input transfer to out_valid when no stall occurs.
REQ-022 SHALL sustain one transfer per cycle in and out when out_ready held 1 (full throughput, including when full).
REQ-023 SHALL hold capacity exactly DEPTH entries; when all v=1 and out_ready=0, in_ready=0 and all stages hold.
REQ-024 SHALL, when full and out_ready=1, accept a new input in the same cycle (simultaneous in/out), count unchanged.
REQ-025 SHALL preserve entry order; no entry duplicated or dropped except by flush or rst.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on flush=1, clear all v[k] at next edge, ignore in_valid, leave d[k] unchanged; an output transfer in the flush cycle still counts as completed.
REQ-028 SHALL update count registered, equal to popcount of v after each edge; range 0..DEPTH.

Reset
REQ-029 SHALL, on rst=1 at posedge clk, set all v[k]=0, all d[k]=INIT, count=0; rst overrides flush and all handshakes.
REQ-030 SHALL present after reset: out_valid=0, out_data=INIT, count=0, in_ready=1 (once rst deasserted).
REQ-031 SHALL discard all in-flight entries when rst asserted mid-operation.

Structure
REQ-032 SHALL place no typedefs in a shared package; the count-width expression SHALL be a localparam in the module.
REQ-033 SHALL instantiate one sub-module per stage, pipe_stage (parameters WIDTH, INIT; ports clk, rst, flush, adv, in_valid, in_data, valid, data), via generate loop.

Verification
REQ-034 SHALL cover reset: WIDTH=8, INIT=8'hA5, DEPTH=3, rst 1 cycle -> out_valid=0, out_data=8'hA5, count=0, in_ready=1.
REQ-035 SHALL cover streaming: DEPTH=3, out_ready=1, push 1,2,3,4 on consecutive cycles -> out_valid first at 3 cycles after push of 1, outputs 1,2,3,4 on consecutive cycles.
REQ-036 SHALL cover fill/stall: DEPTH=3, out_ready=0, push 5 values -> 3 accepted, in_ready=0, count=3; raise out_ready -> outputs in order, count drops to 0.
REQ-037 SHALL cover simultaneous push/pop when full: count=3, in_valid=1, out_ready=1 for 4 cycles -> count stays 3, order preserved.
REQ-038 SHALL cover flush: count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed value never appears.
REQ-039 SHALL cover bubble collapse: DEPTH=4, single entry pushed, out_ready=0 -> entry reaches last stage after 4 cycles, then 3 further pushes accepted, count=4.
